fifo_rr_arbiter_ctrl: RTL

- Controller that drains NUM_SRC source FIFOs of the transmit path into one destination FIFO.
- Uses round-robin arbitration among sources.
- Applies backpressure from the destination almost-full/full flags.
- Runs a small FSM (RESET/INIT/IDLE/ACTIVE/ERROR) with a configurable source-enable mask and a forwarded-word counter.

---
 rtl/fifo_rr_arbiter_ctrl_pkg.sv | 14 +
 rtl/fifo_rr_arbiter_ctrl_pick.sv | 28 ++
 rtl/fifo_rr_arbiter_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/fifo_rr_arbiter_ctrl_pkg.sv
// rtl/fifo_rr_arbiter_ctrl_pkg.sv - shared constants for the transmit-path FIFO arbiter
// One-hot FSM state encodings and default transmit-layer dimensions.
package fifo_rr_arbiter_ctrl_pkg;

  localparam int TX_NUM_SRC    = 4;
  localparam int TX_DATA_WIDTH = 6;

  localparam logic [4:0] ST_RESET  = 5'b00001;
  localparam logic [4:0] ST_INIT   = 5'b00010;
  localparam logic [4:0] ST_IDLE   = 5'b00100;
  localparam logic [4:0] ST_ACTIVE = 5'b01000;
  localparam logic [4:0] ST_ERROR  = 5'b10000;

endpackage

// File: rtl/fifo_rr_arbiter_ctrl_pick.sv
// rtl/fifo_rr_arbiter_ctrl_pick.sv - combinational round-robin priority picker
// Returns the first set request bit searching cyclically from last_grant+1.
module rr_priority_pick
  import fifo_rr_arbiter_ctrl_pkg::*;
#(
  parameter int NUM_SRC   = TX_NUM_SRC,
  parameter int SEL_WIDTH = 2
) (
  input  logic [NUM_SRC-1:0]   req,
  input  logic [SEL_WIDTH-1:0] last_grant,
  output logic [SEL_WIDTH-1:0] grant,
  output logic                 valid
);

  // Walk from the farthest offset down so the nearest requester is written last and wins;
  // NUM_SRC is a power of two, so the SEL_WIDTH-bit sum wraps cyclically on its own.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      if (req[last_grant + SEL_WIDTH'(i)]) begin
        grant = last_grant + SEL_WIDTH'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter_ctrl.sv
// rtl/fifo_rr_arbiter_ctrl.sv - drains NUM_SRC source FIFOs into one destination FIFO
// Round-robin pops with almost-full backpressure, sticky error state and a word counter.
module fifo_rr_arbiter_ctrl
  import fifo_rr_arbiter_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = TX_DATA_WIDTH,
  parameter int NUM_SRC    = TX_NUM_SRC,
  parameter int SEL_WIDTH  = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          init,
  input  logic [NUM_SRC-1:0]            src_mask_in,
  input  logic [NUM_SRC-1:0]            src_empty,
  input  logic [NUM_SRC-1:0]            src_error,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic                          dst_full,
  input  logic                          dst_almost_full,
  input  logic                          dst_error,
  output logic [NUM_SRC-1:0]            src_rd_en,
  output logic                          dst_wr_en,
  output logic [DATA_WIDTH-1:0]         dst_data,
  output logic [SEL_WIDTH-1:0]          grant_id,
  output logic [4:0]                    state,
  output logic                          idle,
  output logic                          error_out,
  output logic [CNT_WIDTH-1:0]          word_count
);

  logic [4:0]           state_q, state_d;
  logic [NUM_SRC-1:0]   mask_q, eligible;
  logic [SEL_WIDTH-1:0] last_grant, pick_idx, wr_sel;
  logic                 pick_valid, any_err, pop, wr_q;

  assign eligible = ~src_empty & mask_q;
  assign any_err  = (|src_error) | dst_error;

  rr_priority_pick #(
    .NUM_SRC  (NUM_SRC),
    .SEL_WIDTH(SEL_WIDTH)
  ) u_pick (
    .req       (eligible),
    .last_grant(last_grant),
    .grant     (pick_idx),
    .valid     (pick_valid)
  );

  // Gating on almost_full leaves room for the one word already in flight.
  assign pop = (state_q == ST_ACTIVE) && !init && !any_err && !dst_full
               && !dst_almost_full && pick_valid;

  always_comb begin
    src_rd_en = '0;
    if (pop) src_rd_en[pick_idx] = 1'b1;
  end

  // Source read data arrives one cycle after the pop, so it is steered by the registered grant.
  always_comb begin
    dst_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (wr_q && (wr_sel == SEL_WIDTH'(i))) dst_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign dst_wr_en = wr_q;
  assign state     = state_q;
  assign idle      = (state_q == ST_IDLE);
  assign error_out = (state_q == ST_ERROR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:            state_d = ST_INIT;
      ST_INIT:             state_d = init ? ST_INIT : ST_IDLE;
      ST_IDLE, ST_ACTIVE:  state_d = init ? ST_INIT : (pick_valid ? ST_ACTIVE : ST_IDLE);
      ST_ERROR:            state_d = ST_ERROR;
      default:             state_d = ST_ERROR;
    endcase
    if ((state_q != ST_RESET) && any_err) state_d = ST_ERROR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RESET;
      mask_q     <= '1;
      last_grant <= SEL_WIDTH'(NUM_SRC - 1);
      grant_id   <= '0;
      word_count <= '0;
      wr_q       <= 1'b0;
      wr_sel     <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= pop;
      if (pop) begin
        wr_sel     <= pick_idx;
        last_grant <= pick_idx;
        grant_id   <= pick_idx;
      end
      if ((state_q == ST_INIT) && init) begin
        mask_q     <= src_mask_in;
        word_count <= '0;
      end else if (wr_q) begin
        word_count <= word_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule
